// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arithmetic ops plus iterative
// shift-add multiply and restoring signed divide (one bit per cycle).
module seq_alu #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   op1,
  input  logic [WIDTH-1:0]   op2,
  input  logic [5:0]         operation,
  input  logic [SHAMT_W-1:0] shift_amount,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero
);

  localparam int CNT_W = SHAMT_W + 1;

  localparam logic [5:0] OP_ADD = 6'd0;
  localparam logic [5:0] OP_SUB = 6'd1;
  localparam logic [5:0] OP_MUL = 6'd2;
  localparam logic [5:0] OP_DIV = 6'd3;
  localparam logic [5:0] OP_SLL = 6'd4;
  localparam logic [5:0] OP_SRL = 6'd5;
  localparam logic [5:0] OP_SLT = 6'd6;
  localparam logic [5:0] OP_AND = 6'd7;
  localparam logic [5:0] OP_OR  = 6'd8;
  localparam logic [5:0] OP_XOR = 6'd9;
  localparam logic [5:0] OP_NOR = 6'd10;
  localparam logic [5:0] OP_SRA = 6'd11;
  localparam logic [5:0] OP_LUI = 6'd12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // Iteration registers shared by MUL and DIV:
  //   MUL: acc = running sum, wa = multiplier (shifts right), wb = multiplicand (shifts left)
  //   DIV: acc = partial remainder, wa = dividend/quotient (shifts left), wb = divisor magnitude
  logic             is_mul;
  logic             neg_q;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] wa;
  logic [WIDTH-1:0] wb;

  logic [WIDTH-1:0] acc_nx;
  logic [WIDTH-1:0] wa_nx;
  logic [WIDTH-1:0] wb_nx;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_diff;
  logic             q_bit;
  logic [WIDTH-1:0] iter_res;

  logic             start_ok;
  logic             multi;
  logic             dbz_now;
  logic [WIDTH-1:0] single_res;

  // Result of every operation that completes on the capture edge.
  // DIV only reaches this path with a zero divisor, hence all ones.
  function automatic logic [WIDTH-1:0] single_op(
    input logic [5:0]         op,
    input logic [WIDTH-1:0]   a,
    input logic [WIDTH-1:0]   b,
    input logic [SHAMT_W-1:0] sh
  );
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    sa = a;
    sb = b;
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_DIV:  return '1;
      OP_SLL:  return a << sh;
      OP_SRL:  return a >> sh;
      OP_SLT:  return (sa < sb) ? WIDTH'(1) : '0;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_NOR:  return ~(a | b);
      OP_SRA:  return sa >>> sh;
      OP_LUI:  return {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      default: return '0;
    endcase
  endfunction

  // Absolute value as an unsigned quantity; the most-negative input maps
  // to 2^(WIDTH-1), which still fits in WIDTH unsigned bits.
  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  assign start_ok   = start && (state == IDLE);
  assign multi      = (operation == OP_MUL) || ((operation == OP_DIV) && (op2 != '0));
  assign dbz_now    = (operation == OP_DIV) && (op2 == '0);
  assign single_res = single_op(operation, op1, op2, shift_amount);

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // One iteration step of the active multi-cycle operation.
  always_comb begin
    acc_nx   = acc;
    wa_nx    = wa;
    wb_nx    = wb;
    rem_sh   = {acc, wa[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, wb};
    q_bit    = 1'b0;
    if (is_mul) begin
      acc_nx = acc + (wa[0] ? wb : '0);
      wa_nx  = wa >> 1;
      wb_nx  = wb << 1;
    end else begin
      // No borrow out of the trial subtraction means the divisor fits.
      q_bit  = ~rem_diff[WIDTH];
      acc_nx = q_bit ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
      wa_nx  = {wa[WIDTH-2:0], q_bit};
    end
  end

  // Value written when leaving ITER; the quotient sign is applied here.
  // Most-negative / -1 yields magnitude 2^(WIDTH-1) with positive sign,
  // whose bit pattern is the most-negative value.
  always_comb begin
    if (is_mul) iter_res = acc_nx;
    else        iter_res = neg_q ? -wa_nx : wa_nx;
  end

  // Control FSM and architecturally visible result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      result      <= '0;
      zero        <= 1'b1;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_ok) begin
            if (multi) begin
              state <= ITER;
              cnt   <= CNT_W'(WIDTH);
            end else begin
              state       <= DONE;
              result      <= single_res;
              zero        <= (single_res == '0);
              div_by_zero <= dbz_now;
            end
          end
        end
        ITER: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state       <= DONE;
            result      <= iter_res;
            zero        <= (iter_res == '0);
            div_by_zero <= 1'b0;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Iteration datapath: loaded on capture, stepped while in ITER.
  always_ff @(posedge clk) begin
    if (start_ok) begin
      is_mul <= (operation == OP_MUL);
      neg_q  <= op1[WIDTH-1] ^ op2[WIDTH-1];
      acc    <= '0;
      if (operation == OP_MUL) begin
        wa <= op2;
        wb <= op1;
      end else begin
        wa <= magnitude(op1);
        wb <= magnitude(op2);
      end
    end else if (state == ITER) begin
      acc <= acc_nx;
      wa  <= wa_nx;
      wb  <= wb_nx;
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=32): directed vectors, random
// operations against an arithmetic reference model, start-during-busy
// and reset-abort scenarios.
module tb_seq_alu;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [5:0]  operation;
  logic [4:0]  shift_amount;
  logic [31:0] result;
  logic        zero;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  int n_assert = 0;
  int n_fail   = 0;

  seq_alu #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .op1          (op1),
    .op2          (op2),
    .operation    (operation),
    .shift_amount (shift_amount),
    .result       (result),
    .zero         (zero),
    .busy         (busy),
    .done         (done),
    .div_by_zero  (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain arithmetic on the opcode's definition.
  task automatic model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, output logic [31:0] res, output logic dbz,
                       output int lat);
    longint sa;
    longint sb;
    longint q;
    dbz = 1'b0;
    lat = 1;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    case (op)
      6'd0:  res = a + b;
      6'd1:  res = a - b;
      6'd2:  begin res = a * b; lat = 33; end
      6'd3:  begin
        if (b == 32'd0) begin
          res = 32'hFFFF_FFFF;
          dbz = 1'b1;
        end else begin
          q   = sa / sb;
          res = q[31:0];
          lat = 33;
        end
      end
      6'd4:  res = a << sh;
      6'd5:  res = a >> sh;
      6'd6:  res = (sa < sb) ? 32'd1 : 32'd0;
      6'd7:  res = a & b;
      6'd8:  res = a | b;
      6'd9:  res = a ^ b;
      6'd10: res = ~(a | b);
      6'd11: res = $signed(a) >>> sh;
      6'd12: res = {b[15:0], 16'h0000};
      default: res = 32'd0;
    endcase
  endtask

  // Issue one operation and check latency, busy, outputs and the single done pulse.
  task automatic run_op(input string tag, input logic [5:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh);
    logic [31:0] er;
    logic        ed;
    int          el;
    int          lat_obs;
    bit          seen;
    model(op, a, b, sh, er, ed, el);
    @(negedge clk);
    start        = 1'b1;
    operation    = op;
    op1          = a;
    op2          = b;
    shift_amount = sh;
    seen         = 1'b0;
    lat_obs      = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start = 1'b0;
      check({tag, "_busy"}, busy, 1'b1);
      if (done) begin
        seen    = 1'b1;
        lat_obs = k;
        break;
      end
    end
    check({tag, "_done_seen"}, seen, 1'b1);
    if (seen) begin
      check({tag, "_latency"}, lat_obs, el);
      check({tag, "_result"}, result, er);
      check({tag, "_zero"}, zero, (er == 32'd0));
      check({tag, "_dbz"}, div_by_zero, ed);
      @(negedge clk);
      check({tag, "_done_pulse"}, done, 1'b0);
      check({tag, "_idle"}, busy, 1'b0);
      check({tag, "_hold"}, result, er);
    end
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [5:0]  rop;
    logic [4:0]  rsh;
    bit          seen;
    int          lat_obs;

    rst          = 1'b1;
    start        = 1'b0;
    op1          = '0;
    op2          = '0;
    operation    = '0;
    shift_amount = '0;
    repeat (2) @(negedge clk);
    check("rst_result", result, 32'd0);
    check("rst_zero", zero, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_dbz", div_by_zero, 1'b0);
    rst = 1'b0;

    // Directed vectors
    run_op("add", 6'd0, 32'd2, 32'd1, 5'd0);
    run_op("sub", 6'd1, 32'd0, 32'd1, 5'd0);
    run_op("mul_neg", 6'd2, -32'sd1000, 32'd4, 5'd0);
    check("mul_neg_const", result, 32'hFFFF_F060);
    run_op("mul_zero", 6'd2, 32'd0, 32'd1, 5'd0);
    run_op("div_neg", 6'd3, -32'sd1000, 32'd4, 5'd0);
    check("div_neg_const", result, 32'hFFFF_FF06);
    run_op("div_by0", 6'd3, 32'd7, 32'd0, 5'd0);
    run_op("div_ovf", 6'd3, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0);
    check("div_ovf_const", result, 32'h8000_0000);
    run_op("sra", 6'd11, 32'hFFFF_FC18, 32'd0, 5'd4);
    check("sra_const", result, 32'hFFFF_FFC1);
    run_op("srl", 6'd5, 32'hFFFF_FC18, 32'd0, 5'd4);
    run_op("lui", 6'd12, 32'd0, 32'h0000_1234, 5'd0);
    check("lui_const", result, 32'h1234_0000);
    run_op("slt", 6'd6, -32'sd1000, 32'd4, 5'd0);
    run_op("div_pos", 6'd3, 32'd1000, -32'sd7, 5'd0);
    run_op("undef", 6'd40, 32'd5, 32'd6, 5'd3);

    // Randomised operations
    for (int i = 0; i < 40; i++) begin
      rop = 6'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      rsh = 5'($urandom);
      run_op("rnd", rop, ra, rb, rsh);
    end

    // start with new operands during MUL iteration is ignored
    @(negedge clk);
    start = 1'b1; operation = 6'd2; op1 = -32'sd1000; op2 = 32'd4;
    seen = 1'b0; lat_obs = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start = (k < 10);
      operation = 6'd0; op1 = 32'd5; op2 = 32'd6;
      if (done) begin
        seen = 1'b1;
        lat_obs = k;
        break;
      end
    end
    start = 1'b0;
    check("busy_start_seen", seen, 1'b1);
    check("busy_start_latency", lat_obs, 33);
    check("busy_start_result", result, 32'hFFFF_F060);
    @(negedge clk);
    check("busy_start_idle", busy, 1'b0);

    // Reset during ITER aborts
    @(negedge clk);
    start = 1'b1; operation = 6'd2; op1 = 32'd9; op2 = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("abort_busy_before", busy, 1'b1);
    rst = 1'b1;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_result", result, 32'd0);
    check("abort_zero", zero, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    check("abort_no_done", seen, 1'b0);
    run_op("post_rst_add", 6'd0, 32'd2, 32'd1, 5'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
